// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and threshold range checks for the fifo_queue_v2 slice.
package fifo_pkg;
  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return a > b ? a : b;
  endfunction
  function automatic bit thresh_ok(input int unsigned af, input int unsigned ae, input int unsigned depth);
    return af >= 1 && af <= depth && ae <= depth - 1;
  endfunction
endpackage

// File: rtl/fifo_regfile.sv
// fifo_regfile: DEPTH x DATA_WIDTH storage, one synchronous write port, one asynchronous read port.
module fifo_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_queue_v2.sv
// fifo_queue_v2: FWFT circular FIFO with thresholds, sticky errors and peak occupancy.
// Optional empty bypass enabled by defining FIFO_BYPASS_EN.
module fifo_queue_v2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_IN,
  input  logic                  pushReq_IN,
  input  logic [DATA_WIDTH-1:0] data_IN,
  input  logic                  popReq_IN,
  output logic [DATA_WIDTH-1:0] data_OUT,
  output logic                  emptyFlag_OUT,
  output logic                  fullFlag_OUT,
  output logic                  almostEmpty_OUT,
  output logic                  almostFull_OUT,
  output logic [ADDR_WIDTH:0]   count_OUT,
  output logic [ADDR_WIDTH:0]   peakCount_OUT,
  output logic                  overflow_OUT,
  output logic                  underflow_OUT,
  input  logic                  clrErr_IN
);
  localparam int DEPTH = int'(depth_of(ADDR_WIDTH));
  localparam int CNT_W = ADDR_WIDTH + 1;
  if (!thresh_ok(AF_THRESH, AE_THRESH, DEPTH)) begin : g_bad_thresh
    $error("fifo_queue_v2: AF_THRESH/AE_THRESH out of range");
  end
  logic [ADDR_WIDTH-1:0] head, tail;
  logic [CNT_W-1:0] cnt, cnt_nxt, peak;
  logic [DATA_WIDTH-1:0] rd_data;
  logic ovf, unf, empty, full, byp, valid_pop, valid_push, wr, rd;
  assign empty = cnt == '0;
  assign full  = cnt == CNT_W'(DEPTH);
`ifdef FIFO_BYPASS_EN
  assign byp = empty & pushReq_IN;
`else
  assign byp = 1'b0;
`endif
  assign valid_pop  = popReq_IN & (!empty | byp);
  assign valid_push = pushReq_IN & (!full | valid_pop);
  // a bypassed word is consumed straight from data_IN, so storage is left untouched
  assign wr = valid_push & !(byp & popReq_IN) & !flush_IN;
  assign rd = valid_pop & !byp & !flush_IN;
  assign cnt_nxt = flush_IN ? '0 : cnt + CNT_W'(wr) - CNT_W'(rd);
  fifo_regfile #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_regfile (
    .clk(clk), .we(wr), .waddr(tail), .wdata(data_IN), .raddr(head), .rdata(rd_data)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      peak <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      if (flush_IN) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (wr) tail <= tail + 1'b1;
        if (rd) head <= head + 1'b1;
      end
      cnt  <= cnt_nxt;
      peak <= clrErr_IN ? cnt_nxt : CNT_W'(max_u(peak, cnt_nxt));
      ovf  <= (pushReq_IN & !valid_push & !flush_IN) | (ovf & !clrErr_IN);
      unf  <= (popReq_IN & !valid_pop & !flush_IN) | (unf & !clrErr_IN);
    end
  assign data_OUT        = byp ? data_IN : empty ? '0 : rd_data;
  assign emptyFlag_OUT   = empty;
  assign fullFlag_OUT    = full;
  assign almostEmpty_OUT = cnt <= CNT_W'(AE_THRESH);
  assign almostFull_OUT  = cnt >= CNT_W'(AF_THRESH);
  assign count_OUT       = cnt;
  assign peakCount_OUT   = peak;
  assign overflow_OUT    = ovf;
  assign underflow_OUT   = unf;
endmodule

// File: tb/tb_fifo_queue_v2.sv
// tb_fifo_queue_v2: directed self-checking bench for fifo_queue_v2 (DATA_WIDTH=8, ADDR_WIDTH=2, AF=3, AE=1).
module tb_fifo_queue_v2;
  logic clk = 1'b0;
  logic reset, flush, push, pop, clr;
  logic [7:0] din, dout;
  logic empty, full, ae, af, ovf, unf;
  logic [2:0] count, peak;
  int checks = 0;
  int failures = 0;
  fifo_queue_v2 #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_THRESH(3), .AE_THRESH(1)) dut (
    .clk(clk), .reset(reset), .flush_IN(flush), .pushReq_IN(push), .data_IN(din),
    .popReq_IN(pop), .data_OUT(dout), .emptyFlag_OUT(empty), .fullFlag_OUT(full),
    .almostEmpty_OUT(ae), .almostFull_OUT(af), .count_OUT(count), .peakCount_OUT(peak),
    .overflow_OUT(ovf), .underflow_OUT(unf), .clrErr_IN(clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic p, input logic q, input logic [7:0] d, input logic f, input logic c);
    push = p; pop = q; din = d; flush = f; clr = c;
  endtask
  task automatic cyc(input logic p, input logic q, input logic [7:0] d, input logic f, input logic c);
    drive(p, q, d, f, c);
    @(posedge clk);
    #1 drive(0, 0, 8'h00, 0, 0);
  endtask
  initial begin
    reset = 1'b1;
    drive(0, 0, 8'h00, 0, 0);
    #2;
    chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_ae", ae, 1);
    chk("rst_af", af, 0); chk("rst_data", dout, 0); chk("rst_count", count, 0);
    #1 reset = 1'b0;
    // 1. fill and drain in order
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 8'hA0 + 8'(i), 0, 0);
      chk("fill_count", count, i + 1);
      chk("fill_af", af, i + 1 >= 3);
      chk("fill_ae", ae, i + 1 <= 1);
      chk("fill_full", full, i == 3);
    end
    chk("fill_peak", peak, 4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", dout, 8'hA0 + 8'(i));
      cyc(0, 1, 8'h00, 0, 0);
    end
    chk("drain_empty", empty, 1); chk("drain_data0", dout, 0);
    // 2. overflow at full, then clear
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'hA0 + 8'(i), 0, 0);
    cyc(1, 0, 8'hA4, 0, 0);
    chk("ovf_set", ovf, 1); chk("ovf_count", count, 4); chk("ovf_head", dout, 8'hA0);
    cyc(0, 0, 8'h00, 0, 1);
    chk("ovf_clr", ovf, 0);
    // 3. push and pop together at full
    cyc(1, 1, 8'hB0, 0, 0);
    chk("pp_count", count, 4); chk("pp_ovf", ovf, 0); chk("pp_head", dout, 8'hA1);
    for (int i = 0; i < 4; i++) begin
      chk("pp_data", dout, i < 3 ? 8'hA1 + 8'(i) : 8'hB0);
      cyc(0, 1, 8'h00, 0, 0);
    end
    chk("pp_empty", empty, 1);
    // 4. wrap with interleaved traffic
    cyc(0, 0, 8'h00, 0, 1);
    chk("wrap_peak0", peak, 0);
    cyc(1, 0, 8'h10, 0, 0);
    cyc(1, 0, 8'h11, 0, 0);
    for (int i = 2; i < 10; i++) begin
      chk("wrap_data", dout, 8'h10 + 8'(i - 2));
      cyc(1, 1, 8'h10 + 8'(i), 0, 0);
      chk("wrap_count", count, 2);
    end
    chk("wrap_data", dout, 8'h18); cyc(0, 1, 8'h00, 0, 0);
    chk("wrap_data", dout, 8'h19); cyc(0, 1, 8'h00, 0, 0);
    chk("wrap_empty", empty, 1); chk("wrap_peak", peak, 2); chk("wrap_unf", unf, 0);
    // 5. underflow behaviour
    cyc(0, 1, 8'h00, 0, 0);
    chk("unf_set", unf, 1);
    cyc(0, 1, 8'h00, 0, 1);
    chk("unf_keep", unf, 1);
    cyc(0, 0, 8'h00, 0, 1);
    chk("unf_clr", unf, 0);
`ifdef FIFO_BYPASS_EN
    drive(1, 1, 8'h5A, 0, 0);
    #1 chk("byp_data", dout, 8'h5A);
    @(posedge clk);
    #1 drive(0, 0, 8'h00, 0, 0);
    chk("byp_count", count, 0); chk("byp_unf", unf, 0); chk("byp_data0", dout, 0);
`else
    drive(1, 1, 8'h5A, 0, 0);
    #1 chk("nobyp_data", dout, 0);
    @(posedge clk);
    #1 drive(0, 0, 8'h00, 0, 0);
    chk("nobyp_count", count, 1); chk("nobyp_unf", unf, 1); chk("nobyp_head", dout, 8'h5A);
    cyc(0, 1, 8'h00, 0, 0);
`endif
    cyc(0, 0, 8'h00, 0, 1);
    chk("pre6_peak", peak, 0); chk("pre6_unf", unf, 0);
    // 6. flush keeps errors and peak; async reset clears without an edge
    cyc(0, 1, 8'h00, 0, 0);
    cyc(1, 0, 8'hC0, 0, 0);
    cyc(1, 0, 8'hC1, 0, 0);
    chk("fl_pre_count", count, 2);
    cyc(1, 1, 8'hC2, 1, 0);
    chk("fl_count", count, 0); chk("fl_empty", empty, 1); chk("fl_data", dout, 0);
    chk("fl_peak", peak, 2); chk("fl_unf", unf, 1); chk("fl_ovf", ovf, 0);
    cyc(1, 0, 8'hD0, 0, 0);
    chk("postfl_head", dout, 8'hD0);
    cyc(1, 0, 8'hD1, 0, 0);
    chk("postfl_count", count, 2);
    #2 reset = 1'b1;
    #1;
    chk("arst_count", count, 0); chk("arst_empty", empty, 1); chk("arst_peak", peak, 0);
    chk("arst_unf", unf, 0); chk("arst_data", dout, 0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_empty", empty, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
